// File: rtl/cordic_iter.sv
// Iterative CORDIC engine: one micro-rotation per cycle, ready/valid on both sides.
// state | meaning:  IDLE | waiting for a request;  RUN | micro-rotation i;  DONE | result held
module cordic_iter #(
   parameter int W    = 16,
   parameter int ITER = 14
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic         mode,
   input  logic [W-1:0] x_in,
   input  logic [W-1:0] y_in,
   input  logic [W-1:0] z_in,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W+1:0] x_out,
   output logic [W+1:0] y_out,
   output logic [W-1:0] z_out,
   output logic         dir
);

   localparam int XW = W + 2;
   localparam int IW = $clog2(W) + 1;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   logic [1:0]           state_q, state_d;
   logic [IW-1:0]        i_q, i_d;
   logic                 mode_q, mode_d;
   logic signed [XW-1:0] x_q, x_d, y_q, y_d;
   logic signed [XW-1:0] x_sh, y_sh;
   logic signed [W-1:0]  z_q, z_d, ang;

   // Table holds round(atan(2^-i) * 2^15 / pi); rescaled for other widths.
   function automatic logic signed [W-1:0] atan_rom(input logic [IW-1:0] idx);
      int a;
      case (int'(idx))
         0:       a = 8192;
         1:       a = 4836;
         2:       a = 2555;
         3:       a = 1297;
         4:       a = 651;
         5:       a = 326;
         6:       a = 163;
         7:       a = 81;
         8:       a = 41;
         9:       a = 20;
         10:      a = 10;
         11:      a = 5;
         12:      a = 3;
         13:      a = 1;
         default: a = 0;
      endcase
      if (W >= 16) a = a << ((W >= 16) ? (W - 16) : 0);
      else         a = a >> ((W < 16) ? (16 - W) : 0);
      return a[W-1:0];
   endfunction

   always_comb begin
      x_sh = x_q >>> i_q;
      y_sh = y_q >>> i_q;
      ang  = atan_rom(i_q);
      dir  = (state_q == S_RUN) && (mode_q ? y_q[XW-1] : !z_q[W-1]);
   end

   always_comb begin
      state_d = state_q;
      i_d     = i_q;
      mode_d  = mode_q;
      x_d     = x_q;
      y_d     = y_q;
      z_d     = z_q;
      case (state_q)
         S_IDLE: begin
            if (in_valid) begin
               x_d     = {{2{x_in[W-1]}}, x_in};
               y_d     = {{2{y_in[W-1]}}, y_in};
               z_d     = z_in;
               mode_d  = mode;
               i_d     = '0;
               state_d = S_RUN;
            end
         end
         S_RUN: begin
            if (dir) begin
               x_d = x_q - y_sh;
               y_d = y_q + x_sh;
               z_d = z_q - ang;
            end else begin
               x_d = x_q + y_sh;
               y_d = y_q - x_sh;
               z_d = z_q + ang;
            end
            i_d = i_q + IW'(1);
            if (i_q == IW'(ITER - 1)) state_d = S_DONE;
         end
         S_DONE: begin
            if (out_ready) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         i_q     <= '0;
         mode_q  <= 1'b0;
         x_q     <= '0;
         y_q     <= '0;
         z_q     <= '0;
      end else begin
         state_q <= state_d;
         i_q     <= i_d;
         mode_q  <= mode_d;
         x_q     <= x_d;
         y_q     <= y_d;
         z_q     <= z_d;
      end
   end

   assign in_ready  = (state_q == S_IDLE);
   assign out_valid = (state_q == S_DONE);
   assign x_out     = x_q;
   assign y_out     = y_q;
   assign z_out     = z_q;

endmodule

// File: tb/tb_cordic_iter.sv
// Directed bench for cordic_iter: a 14-iteration and a 1-iteration instance.
module tb_cordic_iter;

   localparam int ANG [14] = '{8192, 4836, 2555, 1297, 651, 326, 163, 81, 41, 20, 10, 5, 3, 1};

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid, in_valid1;
   logic        mode;
   logic [15:0] x_in, y_in, z_in;
   logic        out_ready;

   logic        in_ready, out_valid, dir;
   logic [17:0] x_out, y_out;
   logic [15:0] z_out;
   logic        in_ready1, out_valid1, dir1;
   logic [17:0] x_out1, y_out1;
   logic [15:0] z_out1;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   cordic_iter #(.W(16), .ITER(14)) u_dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .mode(mode),
      .x_in(x_in), .y_in(y_in), .z_in(z_in), .out_valid(out_valid), .out_ready(out_ready),
      .x_out(x_out), .y_out(y_out), .z_out(z_out), .dir(dir));

   cordic_iter #(.W(16), .ITER(1)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_ready(in_ready1), .mode(mode),
      .x_in(x_in), .y_in(y_in), .z_in(z_in), .out_valid(out_valid1), .out_ready(out_ready),
      .x_out(x_out1), .y_out(y_out1), .z_out(z_out1), .dir(dir1));

   task automatic chk(input string tag, input longint obs, input longint exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic chk_rng(input string tag, input longint obs, input longint lo, input longint hi);
      checks++;
      assert ((obs >= lo && obs <= hi) === 1'b1) else begin
         errors++;
         $error("FAIL %s observed %0d expected %0d..%0d", tag, obs, lo, hi);
      end
   endtask

   function automatic void model(input int itn, input bit md, input int xi, input int yi,
                                 input int zi, output int xo, output int yo, output int zo);
      logic signed [17:0] x, y, xs, ys, xn, yn;
      logic signed [15:0] z;
      bit d;
      x = 18'(xi);
      y = 18'(yi);
      z = 16'(zi);
      for (int k = 0; k < itn; k++) begin
         xs = x >>> k;
         ys = y >>> k;
         d  = md ? y[17] : ~z[15];
         xn = d ? x - ys : x + ys;
         yn = d ? y + xs : y - xs;
         z  = d ? z - 16'(ANG[k]) : z + 16'(ANG[k]);
         x  = xn;
         y  = yn;
      end
      xo = int'(x);
      yo = int'(y);
      zo = int'(z);
   endfunction

   task automatic start(input bit sel, input bit md, input int xi, input int yi, input int zi);
      int n;
      @(negedge clk);
      mode = md;
      x_in = xi[15:0];
      y_in = yi[15:0];
      z_in = zi[15:0];
      if (sel) in_valid1 = 1'b1;
      else     in_valid  = 1'b1;
      n = 0;
      while (!(sel ? in_ready1 : in_ready) && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk("accept_ready", longint'(sel ? in_ready1 : in_ready), 1);
      @(negedge clk);
      in_valid  = 1'b0;
      in_valid1 = 1'b0;
   endtask

   task automatic wait_done(input bit sel, input int lat, output int xo, output int yo, output int zo);
      int n;
      n = 0;
      while (!(sel ? out_valid1 : out_valid) && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk("latency", n, lat);
      xo = sel ? int'($signed(x_out1)) : int'($signed(x_out));
      yo = sel ? int'($signed(y_out1)) : int'($signed(y_out));
      zo = sel ? int'($signed(z_out1)) : int'($signed(z_out));
   endtask

   task automatic finish_xfer(input bit sel);
      @(negedge clk);
      chk("idle_ready", longint'(sel ? in_ready1 : in_ready), 1);
      chk("idle_valid", longint'(sel ? out_valid1 : out_valid), 0);
   endtask

   task automatic run_model(input bit sel, input int itn, input bit md, input int xi,
                            input int yi, input int zi, input string tag);
      int xo, yo, zo, mx, my, mz;
      start(sel, md, xi, yi, zi);
      wait_done(sel, itn, xo, yo, zo);
      model(itn, md, xi, yi, zi, mx, my, mz);
      chk({tag, "_x"}, xo, mx);
      chk({tag, "_y"}, yo, my);
      chk({tag, "_z"}, zo, mz);
      finish_xfer(sel);
   endtask

   initial begin
      int xo, yo, zo, mx, my, mz;
      int acc [3];
      int bx [3];
      int by [3];
      int bz [3];
      int n;

      rst_n = 1'b0;
      in_valid = 1'b0;
      in_valid1 = 1'b0;
      mode = 1'b0;
      x_in = '0;
      y_in = '0;
      z_in = '0;
      out_ready = 1'b1;
      repeat (2) @(negedge clk);
      chk("rst_in_ready", in_ready, 1);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_dir", dir, 0);
      chk("rst_x", x_out, 0);
      chk("rst_z", z_out, 0);
      chk("rst1_in_ready", in_ready1, 1);
      chk("rst1_y", y_out1, 0);
      rst_n = 1'b1;

      // Rotation by +pi/4
      start(0, 0, 10000, 0, 8192);
      chk("rot_dir0", dir, 1);
      wait_done(0, 14, xo, yo, zo);
      model(14, 0, 10000, 0, 8192, mx, my, mz);
      chk("rot_x", xo, mx);
      chk("rot_y", yo, my);
      chk("rot_z", zo, mz);
      chk_rng("rot_x_approx", xo, 11641, 11649);
      chk_rng("rot_y_approx", yo, 11641, 11649);
      chk_rng("rot_z_approx", zo, -4, 4);
      finish_xfer(0);

      // Vectoring from (10000, 10000)
      start(0, 1, 10000, 10000, 0);
      chk("vec_dir0", dir, 0);
      wait_done(0, 14, xo, yo, zo);
      model(14, 1, 10000, 10000, 0, mx, my, mz);
      chk("vec_x", xo, mx);
      chk("vec_y", yo, my);
      chk("vec_z", zo, mz);
      chk_rng("vec_x_approx", xo, 23286, 23294);
      chk_rng("vec_y_approx", yo, -4, 4);
      chk_rng("vec_z_approx", zo, 8188, 8196);
      finish_xfer(0);

      // Backpressure: result must hold while out_ready is low
      out_ready = 1'b0;
      start(0, 0, -5000, 7000, -3000);
      wait_done(0, 14, xo, yo, zo);
      model(14, 0, -5000, 7000, -3000, mx, my, mz);
      chk("bp_x", xo, mx);
      chk("bp_z", zo, mz);
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         chk("bp_hold_valid", out_valid, 1);
         chk("bp_hold_ready", in_ready, 0);
         chk("bp_hold_x", $signed(x_out), mx);
         chk("bp_hold_y", $signed(y_out), my);
         chk("bp_hold_z", $signed(z_out), mz);
      end
      out_ready = 1'b1;
      finish_xfer(0);

      // Reset at iteration 5 discards the operation
      start(0, 0, 10000, 0, 8192);
      repeat (5) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      chk("mid_rst_in_ready", in_ready, 1);
      chk("mid_rst_out_valid", out_valid, 0);
      chk("mid_rst_x", x_out, 0);
      chk("mid_rst_y", y_out, 0);
      chk("mid_rst_z", z_out, 0);
      chk("mid_rst_dir", dir, 0);
      rst_n = 1'b1;
      run_model(0, 14, 1, -7000, 3000, 1000, "post_rst");

      // Back-to-back with in_valid held high
      bx = '{1234, -20000, 32767};
      by = '{-4321, 15000, 32767};
      bz = '{5000, -12000, 0};
      @(negedge clk);
      mode = 1'b0;
      x_in = bx[0][15:0];
      y_in = by[0][15:0];
      z_in = bz[0][15:0];
      in_valid = 1'b1;
      for (int r = 0; r < 3; r++) begin
         n = 0;
         while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
         end
         acc[r] = cyc;
         @(negedge clk);
         if (r < 2) begin
            x_in = bx[r+1][15:0];
            y_in = by[r+1][15:0];
            z_in = bz[r+1][15:0];
         end
         wait_done(0, 14, xo, yo, zo);
         if (r == 2) in_valid = 1'b0;
         model(14, 0, bx[r], by[r], bz[r], mx, my, mz);
         chk("b2b_x", xo, mx);
         chk("b2b_y", yo, my);
         chk("b2b_z", zo, mz);
         chk("b2b_no_ready_in_done", in_ready, 0);
      end
      chk("b2b_gap01", acc[1] - acc[0], 16);
      chk("b2b_gap12", acc[2] - acc[1], 16);
      finish_xfer(0);

      // Boundary operands, ITER=14
      run_model(0, 14, 0, 12000, -9000, -32768, "bnd14_rot");
      run_model(0, 14, 1, -32768, -32768, 0, "bnd14_vec");

      // Boundary operands, ITER=1, hand-derived
      start(1, 0, 1000, 500, -32768);
      chk("bnd1_rot_dir", dir1, 0);
      wait_done(1, 1, xo, yo, zo);
      chk("bnd1_rot_x", xo, 1500);
      chk("bnd1_rot_y", yo, -500);
      chk("bnd1_rot_z", zo, -24576);
      finish_xfer(1);
      start(1, 1, -32768, -32768, 0);
      chk("bnd1_vec_dir", dir1, 1);
      wait_done(1, 1, xo, yo, zo);
      chk("bnd1_vec_x", xo, 0);
      chk("bnd1_vec_y", yo, -65536);
      chk("bnd1_vec_z", zo, -8192);
      finish_xfer(1);
      run_model(1, 1, 0, -32768, 32767, 100, "bnd1_model");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/cordic_iter.md
# cordic_iter

Iterative CORDIC shift-add engine that consumes one rotate/vector request, runs ITER micro-rotations, and returns the updated (x, y, z) triple. It sits downstream of the combinational direction-decision logic. It is the datapath end of that interface: it applies the per-step direction d each cycle, and it regenerates d internally from the sign of z (rotation) or y (vectoring). Ready/valid handshakes on both sides let it drop into the lgsynth-style CORDIC pipeline.

## Interface
Parameters:
- W, 16, width of the input operands and the angle; z full scale ±π maps to ±2^(W-1)
- ITER, 14, number of micro-rotations; legal range 1..W-2

Ports:
- clk  in  1  single clock; all state updates on the rising edge
- rst_n  in  1  reset, synchronous, active-low
- in_valid  in  1  request present
- in_ready  out  1  engine can accept a request
- mode  in  1  0 = rotation (drive z→0), 1 = vectoring (drive y→0)
- x_in, y_in  in  W  two's-complement operands
- z_in  in  W  two's-complement angle
- out_valid  out  1  result held on outputs
- out_ready  in  1  consumer accepts result
- x_out, y_out  out  W+2  two's-complement results, including gain K≈1.6468
- z_out  out  W  residual/accumulated angle
- dir  out  1  direction applied in the current RUN cycle (1 = +1); 0 outside RUN

## Operation
- FSM states:
  - IDLE: in_ready=1. On in_valid, load x,y sign-extended to W+2, load z, latch mode, set i=0, go to RUN.
  - RUN: one micro-rotation per cycle. When i==ITER-1, the update is applied and the state goes to DONE.
  - DONE: out_valid=1 and outputs are stable. On out_ready, go to IDLE.
- Direction:
  - Rotation mode: d=+1 iff z ≥ 0.
  - Vectoring mode: d=+1 iff y < 0.
- Update for d=+1: x ← x − (y>>>i); y ← y + (x>>>i); z ← z − A[i]. For d=−1, the signs of all three terms are inverted. All right-hand sides use pre-update values.
- Shifts are arithmetic.
- x,y are W+2 bits and wrap with no saturation. z is W bits and wraps modulo 2^W.
- Angle ROM: A[i] = round(atan(2^-i)·2^(W-1)/π). For W=16: A[0]=8192, A[1]=4836, A[2]=2555, A[3]=1297.
- in_valid is ignored outside IDLE. The request is not queued; the producer holds it until in_ready.
- No gain compensation is applied. The consumer scales by 1/K.

## Timing
- Reset (rst_n=0 at an edge):
  - Next state is IDLE; in_ready=1, out_valid=0, dir=0.
  - x_out, y_out, z_out and i all reset to 0.
  - Reset mid-RUN or mid-DONE discards the operation with no output.
- Accept at edge t0 (in_valid & in_ready). Iterations occur at edges t0+1 .. t0+ITER.
- out_valid rises after edge t0+ITER, so the result is visible in cycle t0+ITER+1.
- With out_ready=1, the result transfers at edge t0+ITER+1. in_ready is high in the following cycle.
- Minimum spacing between accepts is ITER+2 cycles.
- out_valid and outputs stay constant while out_ready=0, for unbounded stall.
- in_ready and out_valid are never high in the same cycle.
- in_valid and out_ready asserted together in DONE: only the output handshake completes. The input is accepted from IDLE on a later cycle.

## Test plan
- Rotation, W=16, ITER=14: x=10000, y=0, z=8192, mode=0 → after 15 cycles x_out≈11645, y_out≈11645 (±4), z_out∈[−4,4].
- Vectoring: x=10000, y=10000, z=0, mode=1 → x_out≈23290 (±4), y_out∈[−4,4], z_out≈8192 (±4). dir in cycle i=0 is 0 (y>0 gives d=−1).
- Backpressure: hold out_ready=0 for 5 cycles in DONE → out_valid stays 1, outputs unchanged, in_ready=0. Release → one transfer, IDLE next cycle.
- Reset mid-RUN: assert rst_n=0 at iteration 5 → next cycle in_ready=1, out_valid=0, outputs 0. A fresh request then completes normally.
- Back-to-back: in_valid held high, out_ready=1, three requests → accepts exactly ITER+2 cycles apart, each result matches a software CORDIC model bit-exactly.
- Boundaries: z=−32768 in rotation mode, and x=y=−32768 in vectoring mode, run for ITER=1 and ITER=14 → bit-exact against the model, including wrap behaviour.
